// File: rtl/sticky_shift_pkg.sv
// rtl/sticky_shift_pkg.sv - width helpers and stage payload layout shared by the sticky shift pipe
package sticky_shift_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int calc_w(input int n);
        return 2 * n + 3;
    endfunction

    function automatic int calc_sw(input int w);
        return clog2(w) + 1;
    endfunction

    localparam int DEF_N  = 8;
    localparam int DEF_TW = 4;
    localparam int DEF_W  = calc_w(DEF_N);
    localparam int DEF_SW = calc_sw(DEF_W);

    // Field order and names are the contract every stage relies on; the top
    // re-declares this layout at its own N/TW widths.
    typedef struct packed {
        logic              valid;
        logic [DEF_W-1:0]  data;
        logic              sticky;
        logic [DEF_SW-1:0] rem;
        logic              arith;
        logic [DEF_TW-1:0] tag;
    } stage_t;

endpackage

// File: rtl/sticky_shift_pipe_if.sv
// rtl/sticky_shift_pipe_if.sv - input/output beat handshake bundle of the sticky shift pipe
interface sticky_shift_pipe_if #(
    parameter int N  = 8,
    parameter int TW = 4
);
    import sticky_shift_pkg::*;

    localparam int W  = calc_w(N);
    localparam int SW = calc_sw(W);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [SW-1:0] in_shift;
    logic          in_arith;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_z;
    logic [TW-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_shift, in_arith, in_tag, out_ready,
        input  in_ready, out_valid, out_z, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_shift, in_arith, in_tag, out_ready,
        output in_ready, out_valid, out_z, out_tag
    );

endinterface

// File: rtl/sticky_shift_stage.sv
// rtl/sticky_shift_stage.sv - one register stage: shifts by its slice of the shift amount, folds ejected bits into sticky
module sticky_shift_stage
    import sticky_shift_pkg::*;
#(
    parameter int  W  = DEF_W,
    parameter int  SW = DEF_SW,
    parameter int  LO = 0,
    parameter int  NB = DEF_SW,
    parameter type payload_t = sticky_shift_pkg::stage_t
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     adv_i,
    input  payload_t d_i,
    output payload_t q_o
);

    localparam logic [31:0] SLICE = 32'(((1 << NB) - 1) << LO);

    payload_t    q_d;
    payload_t    q_q;
    logic [31:0] amt;
    logic        fill;

    always_comb begin
        q_d     = d_i;
        fill    = d_i.arith & d_i.data[W-1];
        amt     = 32'(d_i.rem) & SLICE;
        q_d.rem = d_i.rem & ~SW'(SLICE);
        // A slice worth W or more flushes every remaining bit into sticky.
        if (amt >= 32'(W)) begin
            q_d.data   = {W{fill}};
            q_d.sticky = d_i.sticky | (|d_i.data);
        end else begin
            q_d.data   = W'($signed({fill, d_i.data}) >>> amt);
            q_d.sticky = d_i.sticky | (|(d_i.data & ~({W{1'b1}} << amt)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q.valid <= 1'b0;
        end else if (adv_i) begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/sticky_shift_pipe.sv
// rtl/sticky_shift_pipe.sv - pipelined right shifter with exact sticky bit in out_z[0]
// Optional STICKY_SHIFT_CNT_EN adds sticky_cnt, a saturating count of sticky-set output transfers.
module sticky_shift_pipe
    import sticky_shift_pkg::*;
#(
    parameter int N      = 8,
    parameter int STAGES = 2,
    parameter int TW     = 4
) (
    input logic                clk,
    input logic                rst_n,
    sticky_shift_pipe_if.slave bus
`ifdef STICKY_SHIFT_CNT_EN
    ,
    output logic [15:0]        sticky_cnt
`endif
);

    localparam int W  = calc_w(N);
    localparam int SW = calc_sw(W);
    localparam int NB = (SW + STAGES - 1) / STAGES;

    typedef struct packed {
        logic          valid;
        logic [W-1:0]  data;
        logic          sticky;
        logic [SW-1:0] rem;
        logic          arith;
        logic [TW-1:0] tag;
    } pipe_t;

    pipe_t        in_s;
    pipe_t        st [STAGES];
    pipe_t        last;
    logic         adv;
    logic [W-1:0] z;

    // One global advance: the whole pipe moves or holds as a unit.
    assign adv          = !last.valid | bus.out_ready;
    assign bus.in_ready = adv;

    assign in_s = '{valid: bus.in_valid, data: bus.in_a, sticky: 1'b0,
                    rem: bus.in_shift, arith: bus.in_arith, tag: bus.in_tag};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_t stage_in;
        if (k == 0) begin : g_first
            assign stage_in = in_s;
        end else begin : g_next
            assign stage_in = st[k-1];
        end
        sticky_shift_stage #(
            .W        (W),
            .SW       (SW),
            .LO       (k * NB),
            .NB       (NB),
            .payload_t(pipe_t)
        ) u_stage (
            .clk  (clk),
            .rst_n(rst_n),
            .adv_i(adv),
            .d_i  (stage_in),
            .q_o  (st[k])
        );
    end

    assign last          = st[STAGES-1];
    assign z             = {last.data[W-1:1], last.data[0] | last.sticky};
    assign bus.out_valid = last.valid;
    assign bus.out_z     = z;
    assign bus.out_tag   = last.tag;

`ifdef STICKY_SHIFT_CNT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (last.valid && bus.out_ready && z[0] && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sticky_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sticky_shift_pipe.sv
// tb/tb_sticky_shift_pipe.sv - vector table plus stall, reset and counter sequences for sticky_shift_pipe
module tb_sticky_shift_pipe;

    localparam int N      = 8;
    localparam int TW     = 4;
    localparam int STAGES = 2;
    localparam int NV     = 20;

    typedef struct {
        logic [18:0] a;
        logic [5:0]  sh;
        logic        ar;
        logic [18:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    sticky_shift_pipe_if #(.N(N), .TW(TW)) bus ();

`ifdef STICKY_SHIFT_CNT_EN
    logic [15:0] sticky_cnt;
`endif

    sticky_shift_pipe #(.N(N), .STAGES(STAGES), .TW(TW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
`ifdef STICKY_SHIFT_CNT_EN
        ,
        .sticky_cnt(sticky_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_shift  = '0;
        bus.in_arith  = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{19'h00013, 6'd2,  1'b0, 19'h00005};
        vecs[1]  = '{19'h40000, 6'd25, 1'b0, 19'h00001};
        vecs[2]  = '{19'h40000, 6'd25, 1'b1, 19'h7FFFF};
        vecs[3]  = '{19'h7FFFF, 6'd25, 1'b1, 19'h7FFFF};
        vecs[4]  = '{19'h00010, 6'd4,  1'b0, 19'h00001};
        vecs[5]  = '{19'h00010, 6'd3,  1'b0, 19'h00002};
        vecs[6]  = '{19'h12345, 6'd0,  1'b0, 19'h12345};
        vecs[7]  = '{19'h12344, 6'd0,  1'b1, 19'h12344};
        vecs[8]  = '{19'h40000, 6'd18, 1'b0, 19'h00001};
        vecs[9]  = '{19'h40000, 6'd18, 1'b1, 19'h7FFFF};
        vecs[10] = '{19'h00002, 6'd19, 1'b0, 19'h00001};
        vecs[11] = '{19'h00000, 6'd19, 1'b1, 19'h00000};
        vecs[12] = '{19'h7FFFF, 6'd63, 1'b0, 19'h00001};
        vecs[13] = '{19'h7FFFE, 6'd1,  1'b1, 19'h7FFFF};
        vecs[14] = '{19'h7FFFE, 6'd1,  1'b0, 19'h3FFFF};
        vecs[15] = '{19'h00100, 6'd9,  1'b0, 19'h00001};
        vecs[16] = '{19'h00100, 6'd7,  1'b0, 19'h00002};
        vecs[17] = '{19'h5A5A5, 6'd4,  1'b1, 19'h7DA5B};
        vecs[18] = '{19'h5A5A5, 6'd4,  1'b0, 19'h05A5B};
        vecs[19] = '{19'h00003, 6'd18, 1'b1, 19'h00001};

        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", 32'(bus.out_valid), 0);
        chk("reset_in_ready", 32'(bus.in_ready), 1);
`ifdef STICKY_SHIFT_CNT_EN
        chk("reset_sticky_cnt", 32'(sticky_cnt), 0);
`endif

        for (int i = 0; i < NV; i++) begin
            int lat;
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_a     = vecs[i].a;
            bus.in_shift = vecs[i].sh;
            bus.in_arith = vecs[i].ar;
            bus.in_tag   = 4'(i);
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            lat = 1;
            @(negedge clk);
            while (!bus.out_valid && lat < 10) begin
                lat++;
                @(negedge clk);
            end
            chk($sformatf("vec%0d_latency", i), 32'(lat), STAGES);
            chk($sformatf("vec%0d_z", i), 32'(bus.out_z), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_tag", i), 32'(bus.out_tag), 32'(i % 16));
        end

        begin : stall_seq
            int          sent;
            int          got;
            logic        held;
            logic [18:0] hold_z;
            logic [3:0]  hold_tag;
            sent = 0;
            got  = 0;
            held = 1'b0;
            for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
                @(negedge clk);
                bus.out_ready = !(cyc >= 4 && cyc < 7);
                bus.in_valid  = (sent < 8);
                if (sent < 8) begin
                    bus.in_a     = vecs[sent].a;
                    bus.in_shift = vecs[sent].sh;
                    bus.in_arith = vecs[sent].ar;
                    bus.in_tag   = 4'(sent);
                end
                #1;
                chk($sformatf("stall_in_ready_c%0d", cyc), 32'(bus.in_ready),
                    32'(!(cyc >= 4 && cyc < 7)));
                if (held) begin
                    chk($sformatf("stall_hold_z_c%0d", cyc), 32'(bus.out_z), 32'(hold_z));
                    chk($sformatf("stall_hold_tag_c%0d", cyc), 32'(bus.out_tag), 32'(hold_tag));
                end
                held = 1'b0;
                if (bus.out_valid) begin
                    if (bus.out_ready) begin
                        chk($sformatf("stall_tag_%0d", got), 32'(bus.out_tag), 32'(got));
                        chk($sformatf("stall_z_%0d", got), 32'(bus.out_z), 32'(vecs[got].exp));
                        got++;
                    end else begin
                        held     = 1'b1;
                        hold_z   = bus.out_z;
                        hold_tag = bus.out_tag;
                    end
                end
                if (bus.in_valid && bus.in_ready) sent++;
            end
            chk("stall_beats_out", 32'(got), 8);
        end

        @(negedge clk);
        drive_idle();
        bus.in_valid = 1'b1;
        bus.in_a     = vecs[0].a;
        bus.in_shift = vecs[0].sh;
        bus.in_tag   = 4'hA;
        @(negedge clk);
        bus.in_tag   = 4'hB;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
`ifdef STICKY_SHIFT_CNT_EN
        chk("rst_sticky_cnt", 32'(sticky_cnt), 0);
`endif
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("rst_no_stale_c%0d", c), 32'(bus.out_valid), 0);
        end

`ifdef STICKY_SHIFT_CNT_EN
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = 19'h00001;
        bus.in_shift = 6'd0;
        bus.in_arith = 1'b0;
        repeat (70010) @(negedge clk);
        chk("cnt_saturated", 32'(sticky_cnt), 32'h0000FFFF);
        repeat (5) @(negedge clk);
        chk("cnt_holds", 32'(sticky_cnt), 32'h0000FFFF);
        bus.in_valid = 1'b0;
`endif

        drive_idle();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
